lcd_num_formatter: RTL and testbench



---
 rtl/lcd_fmt_pkg.sv | 22 ++
 rtl/bcd_shift_conv.sv | 67 ++++++
 rtl/lcd_num_formatter.sv | 136 +++++++++++++
 tb/tb_lcd_num_formatter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/lcd_fmt_pkg.sv
// Shared constants, FSM encoding and helpers for the LCD numeric formatter.
package lcd_fmt_pkg;

  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] ASC_DASH  = 8'h2D;
  localparam logic [7:0] ASC_SPACE = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_STORE,
    ST_COMMIT
  } fmt_state_e;

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_shift_conv.sv
// Iterative double-dabble: binary value -> DIGITS packed BCD nibbles in VAL_W cycles.
module bcd_shift_conv #(
  parameter int VAL_W  = 16,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [VAL_W-1:0]      value,
  output logic                  busy,
  output logic [DIGITS*4-1:0]   bcd,
  output logic                  done_pulse
);

  localparam int BW    = DIGITS * 4;
  localparam int CNT_W = $clog2(VAL_W + 1);

  logic [VAL_W-1:0] sh_q, sh_d;
  logic [BW-1:0]    bcd_q, bcd_d, adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++)
      if (bcd_q[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
  end

  // The load cycle already performs the first shift: with a cleared
  // accumulator the add-3 step is a no-op, so VAL_W cycles cover VAL_W shifts.
  always_comb begin
    sh_d   = sh_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (load) begin
      sh_d   = value << 1;
      bcd_d  = BW'(value[VAL_W-1]);
      cnt_d  = CNT_W'(VAL_W - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      sh_d   = sh_q << 1;
      bcd_d  = {adj[BW-2:0], sh_q[VAL_W-1]};
      cnt_d  = cnt_q - 1'b1;
      busy_d = (cnt_q != CNT_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy       = busy_q;
  assign bcd        = bcd_q;
  assign done_pulse = busy_q && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/lcd_num_formatter.sv
// Snapshots NUM_CH readings, converts them through one shared BCD engine and
// publishes all ASCII digit strings together on a single commit edge.
module lcd_num_formatter
  import lcd_fmt_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int VAL_W    = 16,
  parameter int DIGITS   = 3,
  parameter int BLANK_LZ = 0
) (
  input  logic                       clk_1MHz,
  input  logic                       rst,
  input  logic                       sample,
  input  logic [NUM_CH*VAL_W-1:0]    values,
  input  logic [NUM_CH-1:0]          ch_valid,
  output logic                       busy,
  output logic                       done,
  output logic [NUM_CH*DIGITS*8-1:0] ascii
);

  localparam int SW   = DIGITS * 8;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam longint unsigned MAXV = pow10(DIGITS) - 1;
  localparam bit CLAMP_ON = (VAL_W < 64) && (MAXV < (64'd1 << VAL_W));
  localparam logic [VAL_W-1:0] MAXV_T = VAL_W'(MAXV);
  localparam logic [NUM_CH-1:0][SW-1:0] DASHES = {NUM_CH*DIGITS{ASC_DASH}};

  fmt_state_e state_q, state_d;

  logic [NUM_CH-1:0][VAL_W-1:0] snap_val_q;
  logic [NUM_CH-1:0]            snap_vld_q;
  logic [NUM_CH-1:0][SW-1:0]    shadow_q, ascii_q;
  logic [CH_W-1:0]              ch_idx_q;
  logic                         pending_q, done_q;

  logic                 capture, eng_load, store_en, commit, last_ch, restart;
  logic                 eng_busy, eng_done;
  logic [VAL_W-1:0]     sel_val, eng_val;
  logic [DIGITS*4-1:0]  eng_bcd;
  logic [SW-1:0]        fmt;
  logic [3:0]           nib;
  logic                 lz;

  assign last_ch = (ch_idx_q == CH_W'(NUM_CH - 1));
  assign restart = pending_q || sample;

  always_ff @(posedge clk_1MHz) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (sample) state_d = ST_CONV;
      ST_CONV:   if (eng_done) state_d = ST_STORE;
      ST_STORE:  state_d = last_ch ? ST_COMMIT : ST_CONV;
      ST_COMMIT: state_d = restart ? ST_CONV : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    eng_load = (state_q == ST_CONV) && !eng_busy;
    store_en = (state_q == ST_STORE);
    commit   = (state_q == ST_COMMIT);
    capture  = ((state_q == ST_IDLE) && sample) || (commit && restart);
  end

  assign sel_val = snap_val_q[ch_idx_q];
  assign eng_val = (CLAMP_ON && (sel_val > MAXV_T)) ? MAXV_T : sel_val;

  bcd_shift_conv #(
    .VAL_W  (VAL_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk        (clk_1MHz),
    .rst        (rst),
    .load       (eng_load),
    .value      (eng_val),
    .busy       (eng_busy),
    .bcd        (eng_bcd),
    .done_pulse (eng_done)
  );

  // Scan from the most-significant digit; lz stays set while only zeros seen.
  always_comb begin
    fmt = '0;
    nib = '0;
    lz  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = eng_bcd[i*4 +: 4];
      lz  = lz && (nib == 4'd0);
      if (!snap_vld_q[ch_idx_q])
        fmt[i*8 +: 8] = ASC_DASH;
      else if ((BLANK_LZ != 0) && lz && (i != 0))
        fmt[i*8 +: 8] = ASC_SPACE;
      else
        fmt[i*8 +: 8] = ASC_ZERO + {4'h0, nib};
    end
  end

  always_ff @(posedge clk_1MHz) begin
    if (rst) begin
      snap_val_q <= '0;
      snap_vld_q <= '0;
      shadow_q   <= DASHES;
      ascii_q    <= DASHES;
      ch_idx_q   <= '0;
      pending_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= commit;
      if (capture) begin
        snap_val_q <= values;
        snap_vld_q <= ch_valid;
        ch_idx_q   <= '0;
      end else if (store_en && !last_ch) begin
        ch_idx_q <= ch_idx_q + 1'b1;
      end
      if (store_en) shadow_q[ch_idx_q] <= fmt;
      if (commit) ascii_q <= shadow_q;
      // A sample seen during COMMIT restarts directly, so pending only
      // needs to remember requests from CONV/STORE.
      if (commit)
        pending_q <= 1'b0;
      else if (sample && (state_q == ST_CONV || state_q == ST_STORE))
        pending_q <= 1'b1;
    end
  end

  assign done  = done_q;
  assign ascii = ascii_q;

endmodule

// File: tb/tb_lcd_num_formatter.sv
// Directed bench: vector table for both blanking modes plus pending/reset sequences.
module tb_lcd_num_formatter;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample;
  logic [31:0] values;
  logic [1:0]  ch_valid;
  logic        busy0, done0, busy1, done1;
  logic [47:0] ascii0, ascii1;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  lcd_num_formatter #(.NUM_CH(2), .VAL_W(16), .DIGITS(3), .BLANK_LZ(0)) dut0 (
    .clk_1MHz (clk), .rst (rst), .sample (sample), .values (values),
    .ch_valid (ch_valid), .busy (busy0), .done (done0), .ascii (ascii0)
  );

  lcd_num_formatter #(.NUM_CH(2), .VAL_W(16), .DIGITS(3), .BLANK_LZ(1)) dut1 (
    .clk_1MHz (clk), .rst (rst), .sample (sample), .values (values),
    .ch_valid (ch_valid), .busy (busy1), .done (done1), .ascii (ascii1)
  );

  typedef struct {
    logic [15:0] v1;
    logic [15:0] v0;
    logic [1:0]  vld;
    logic [47:0] e0;
    logic [47:0] e1;
  } vec_t;

  vec_t tbl[8];

  task automatic check_int(input string name, input int got, input int exp);
    total++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic check_str(input string name, input logic [47:0] got, input logic [47:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got \"%s\" (%h) expected \"%s\" (%h)", name, got, got, exp, exp);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat, bz;
    bit seen;
    @(negedge clk);
    values = {v.v1, v.v0}; ch_valid = v.vld; sample = 1'b1;
    @(negedge clk);
    sample = 1'b0; lat = 0; bz = 0; seen = 1'b0;
    while (!seen && lat < 100) begin
      if (busy0) bz++;
      @(negedge clk);
      lat++;
      if (done0) seen = 1'b1;
    end
    check_int($sformatf("v%0d_latency", idx), lat, 35);
    check_int($sformatf("v%0d_busy_cycles", idx), bz, 35);
    check_int($sformatf("v%0d_done_blank_dut", idx), int'(done1), 1);
    check_str($sformatf("v%0d_ascii", idx), ascii0, v.e0);
    check_str($sformatf("v%0d_ascii_blank", idx), ascii1, v.e1);
    check_int($sformatf("v%0d_busy_after", idx), int'(busy0), 0);
    @(negedge clk);
    check_int($sformatf("v%0d_done_width", idx), int'(done0), 0);
  endtask

  initial begin
    int ndone, t1, t2;
    tbl[0] = '{16'd98,    16'd72,   2'b11, "098072", " 98 72"};
    tbl[1] = '{16'd65535, 16'd1234, 2'b11, "999999", "999999"};
    tbl[2] = '{16'd999,   16'd0,    2'b11, "999000", "999  0"};
    tbl[3] = '{16'd55,    16'd60,   2'b01, "---060", "--- 60"};
    tbl[4] = '{16'd0,     16'd7,    2'b11, "000007", "  0  7"};
    tbl[5] = '{16'd100,   16'd40,   2'b11, "100040", "100 40"};
    tbl[6] = '{16'd5,     16'd5,    2'b00, "------", "------"};
    tbl[7] = '{16'd1000,  16'd10,   2'b10, "999---", "999---"};

    rst = 1'b1; sample = 1'b0; values = '0; ch_valid = '0;
    repeat (3) @(negedge clk);
    check_str("reset_ascii", ascii0, "------");
    check_str("reset_ascii_blank", ascii1, "------");
    check_int("reset_busy", int'(busy0), 0);
    check_int("reset_done", int'(done0), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_int("idle_busy", int'(busy0), 0);

    for (int i = 0; i < 8; i++) run_vec(tbl[i], i);

    // Pending: three requests while busy collapse to one rerun from the COMMIT snapshot.
    @(negedge clk);
    values = {16'd11, 16'd22}; ch_valid = 2'b11; sample = 1'b1;
    @(negedge clk);
    sample = 1'b0; ndone = 0; t1 = 0; t2 = 0;
    for (int c = 1; c <= 110; c++) begin
      sample = (c - 1 == 5 || c - 1 == 20 || c - 1 == 25);
      if (c - 1 == 10) values = {16'd333, 16'd444};
      @(negedge clk);
      if (done0) begin
        ndone++;
        if (ndone == 1) begin
          t1 = c;
          check_str("pend_first_ascii", ascii0, "011022");
          values = {16'd555, 16'd666};
        end else if (ndone == 2) begin
          t2 = c;
          check_str("pend_second_ascii", ascii0, "333444");
        end
      end
      if (c == 50) begin
        check_str("pend_no_tearing", ascii0, "011022");
        check_int("pend_busy_between", int'(busy0), 1);
      end
    end
    sample = 1'b0;
    check_int("pend_done_count", ndone, 2);
    check_int("pend_first_lat", t1, 35);
    check_int("pend_second_lat", t2, 70);
    check_int("pend_idle_busy", int'(busy0), 0);

    // Reset mid-conversion aborts: dashes, idle, no done.
    @(negedge clk);
    values = {16'd123, 16'd45}; ch_valid = 2'b11; sample = 1'b1;
    @(negedge clk);
    sample = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_str("rst_mid_ascii", ascii0, "------");
    check_str("rst_mid_ascii_blank", ascii1, "------");
    check_int("rst_mid_busy", int'(busy0), 0);
    check_int("rst_mid_done", int'(done0), 0);
    rst = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done0 || busy0) ndone++;
    end
    check_int("rst_no_done_after", ndone, 0);
    run_vec(tbl[0], 8);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
